// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: grants one requester at a time, sends its header flit plus an
// optional data flit, then holds an idle gap. Define SB_ARB_PRIO0_EN for requester-0 strict priority.
module sb_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int GAP_CYCLES = 4
) (
   input  logic                  clk_100MHz,
   input  logic                  reset_n,
   input  logic                  enable_i,
   input  logic [NUM_REQ-1:0]    req_i,
   input  logic [64*NUM_REQ-1:0] hdr_i,
   input  logic [2*NUM_REQ-1:0]  dlen_i,
   input  logic [64*NUM_REQ-1:0] data_i,
   output logic [63:0]           tx_data_o,
   output logic                  tx_valid_o,
   input  logic                  tx_ready_i,
   output logic [NUM_REQ-1:0]    grant_o,
   output logic [NUM_REQ-1:0]    ack_o,
   output logic                  busy_o
);

   // state | meaning
   // IDLE  | no owner; arbitrate when enable_i and any request
   // HDR   | presenting the latched header flit
   // DATA  | presenting the latched data flit (32b zero-extended or 64b)
   // GAP   | idle gap so the far-end deserializer can realign

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   state_t             r_state;
   logic [PW-1:0]      r_rr_ptr;
   logic [CW-1:0]      r_gap_cnt;
   logic [63:0]        r_data;
   logic [1:0]         r_dlen;
   logic [63:0]        r_tx_data;
   logic               r_tx_valid;
   logic [NUM_REQ-1:0] r_grant;
   logic [NUM_REQ-1:0] r_ack;

   logic               w_found;
   logic               w_found_hi;
   logic [PW-1:0]      w_win_hi;
   logic [PW-1:0]      w_win_lo;
   logic [PW-1:0]      w_win;
   logic               w_ptr_upd;
   logic [PW-1:0]      w_ptr_next;
   logic [NUM_REQ-1:0] w_win_oh;
   logic [63:0]        w_hdr_sel;
   logic [63:0]        w_data_sel;
   logic [1:0]         w_dlen_sel;

   // Round robin: lowest requester at or above the pointer, else lowest overall (wrap).
   always_comb begin
      w_found    = |req_i;
      w_found_hi = 1'b0;
      w_win_hi   = '0;
      w_win_lo   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            w_win_lo = PW'(i);
            if (PW'(i) >= r_rr_ptr) begin
               w_win_hi   = PW'(i);
               w_found_hi = 1'b1;
            end
         end
      end
      w_win     = w_found_hi ? w_win_hi : w_win_lo;
      w_ptr_upd = 1'b1;
`ifdef SB_ARB_PRIO0_EN
      if (req_i[0]) begin
         w_win     = '0;
         w_ptr_upd = 1'b0;
      end
`endif
      w_ptr_next = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + PW'(1);
   end

   always_comb begin
      w_win_oh   = '0;
      w_hdr_sel  = '0;
      w_data_sel = '0;
      w_dlen_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PW'(i) == w_win) begin
            w_win_oh[i] = 1'b1;
            w_hdr_sel   = hdr_i[64*i +: 64];
            w_data_sel  = data_i[64*i +: 64];
            w_dlen_sel  = dlen_i[2*i +: 2];
         end
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= '0;
         r_gap_cnt  <= '0;
         r_data     <= '0;
         r_dlen     <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_grant    <= '0;
         r_ack      <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            ST_IDLE: begin
               if (enable_i && w_found) begin
                  r_state    <= ST_HDR;
                  r_data     <= w_data_sel;
                  r_dlen     <= w_dlen_sel;
                  r_tx_data  <= w_hdr_sel;
                  r_tx_valid <= 1'b1;
                  r_grant    <= w_win_oh;
                  if (w_ptr_upd) begin
                     r_rr_ptr <= w_ptr_next;
                  end
               end
            end
            ST_HDR: begin
               if (tx_ready_i) begin
                  if (r_dlen == 2'b00) begin
                     r_state    <= ST_GAP;
                     r_gap_cnt  <= '0;
                     r_tx_valid <= 1'b0;
                     r_tx_data  <= '0;
                     r_ack      <= r_grant;
                  end else begin
                     r_state   <= ST_DATA;
                     r_tx_data <= (r_dlen == 2'b01) ? {32'd0, r_data[31:0]} : r_data;
                  end
               end
            end
            ST_DATA: begin
               if (tx_ready_i) begin
                  r_state    <= ST_GAP;
                  r_gap_cnt  <= '0;
                  r_tx_valid <= 1'b0;
                  r_tx_data  <= '0;
                  r_ack      <= r_grant;
               end
            end
            ST_GAP: begin
               // grant stays visible only during the first gap cycle
               r_grant <= '0;
               if (r_gap_cnt == CW'(GAP_CYCLES - 1)) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + CW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign tx_data_o  = r_tx_data;
   assign tx_valid_o = r_tx_valid;
   assign grant_o    = r_grant;
   assign ack_o      = r_ack;
   assign busy_o     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Bench for sb_tx_arbiter (default build, round robin): scoreboard of expected flits and acks.
module tb_sb_tx_arbiter;
   localparam int N   = 4;
   localparam int GAP = 4;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            enable = 1'b0;
   logic [N-1:0]    req = '0;
   logic [64*N-1:0] hdr = '0;
   logic [2*N-1:0]  dlen = '0;
   logic [64*N-1:0] data = '0;
   logic [63:0]     tx_data_o;
   logic            tx_valid_o;
   logic            tx_ready = 1'b0;
   logic [N-1:0]    grant_o;
   logic [N-1:0]    ack_o;
   logic            busy_o;

   always #5 clk = ~clk;

   sb_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP)) dut (
      .clk_100MHz (clk),
      .reset_n    (reset_n),
      .enable_i   (enable),
      .req_i      (req),
      .hdr_i      (hdr),
      .dlen_i     (dlen),
      .data_i     (data),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready),
      .grant_o    (grant_o),
      .ack_o      (ack_o),
      .busy_o     (busy_o)
   );

   typedef struct {
      logic [63:0]  data;
      logic [N-1:0] gnt;
      logic         last;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         mon_e;
   int           n_vec = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           last_acc = 0;
   int           gap;
   bit           have_acc = 0;
   bit           gap_exact = 0;
   logic         prev_valid = 1'b0;
   logic [N-1:0] pend_ack = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Flit/ack scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         pend_ack   = '0;
         prev_valid = 1'b0;
         have_acc   = 0;
      end else begin
         n_vec++;
         if (ack_o !== pend_ack) begin
            n_err++;
            $display("FAIL ack cycle %0d: ack_o=%b want %b", cyc, ack_o, pend_ack);
         end
         pend_ack = '0;
         if (tx_valid_o === 1'b1 && prev_valid !== 1'b1 && have_acc) begin
            gap = cyc - last_acc - 1;
            n_vec++;
            if (gap_exact ? (gap != GAP + 1) : (gap < GAP + 1)) begin
               n_err++;
               $display("FAIL gap cycle %0d: %0d idle cycles, want %s%0d", cyc, gap,
                        gap_exact ? "" : ">=", GAP + 1);
            end
         end
         prev_valid = tx_valid_o;
         if (tx_valid_o === 1'b1 && tx_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL flit cycle %0d: unexpected flit %h grant %b", cyc, tx_data_o, grant_o);
            end else begin
               mon_e = exp_q.pop_front();
               if (tx_data_o !== mon_e.data || grant_o !== mon_e.gnt) begin
                  n_err++;
                  $display("FAIL flit cycle %0d: data %h grant %b, want %h grant %b",
                           cyc, tx_data_o, grant_o, mon_e.data, mon_e.gnt);
               end
               if (mon_e.last) pend_ack = mon_e.gnt;
            end
            last_acc = cyc;
            have_acc = 1;
         end
      end
   end

   function automatic exp_t mk(logic [63:0] d, logic [N-1:0] g, logic l);
      exp_t e;
      e.data = d;
      e.gnt  = g;
      e.last = l;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      for (int k = 0; k < budget && exp_q.size() != 0; k++) step();
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 40 && busy_o !== 1'b0; k++) step();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) step();
      n_vec += 5;
      if (tx_data_o !== 64'd0) begin n_err++; $display("FAIL reset tx_data: %h want 0", tx_data_o); end
      if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL reset tx_valid: %b want 0", tx_valid_o); end
      if (grant_o !== '0) begin n_err++; $display("FAIL reset grant: %b want 0", grant_o); end
      if (ack_o !== '0) begin n_err++; $display("FAIL reset ack: %b want 0", ack_o); end
      if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset busy: %b want 0", busy_o); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_hdr_only();
      logic [63:0] h;
      h = 64'hA5A5_0000_0000_0001;
      enable = 1'b1;
      tx_ready = 1'b1;
      hdr[64*1 +: 64] = h;
      dlen[2*1 +: 2] = 2'b00;
      req = 4'b0010;
      exp_q.push_back(mk(h, 4'b0010, 1'b1));
      step();
      n_vec += 3;
      if (grant_o !== 4'b0010) begin n_err++; $display("FAIL hdr_only grant: %b want 0010", grant_o); end
      if (tx_valid_o !== 1'b1) begin n_err++; $display("FAIL hdr_only valid: %b want 1", tx_valid_o); end
      if (busy_o !== 1'b1) begin n_err++; $display("FAIL hdr_only busy: %b want 1", busy_o); end
      step();
      n_vec += 2;
      if (grant_o !== 4'b0010) begin n_err++; $display("FAIL hdr_only gap1 grant: %b want 0010", grant_o); end
      if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL hdr_only gap1 valid: %b want 0", tx_valid_o); end
      req = '0;
      step();
      n_vec++;
      if (grant_o !== '0) begin n_err++; $display("FAIL hdr_only gap2 grant: %b want 0", grant_o); end
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL hdr_only idle %0d valid: %b want 0", k, tx_valid_o); end
         step();
      end
      n_vec++;
      if (busy_o !== 1'b0) begin n_err++; $display("FAIL hdr_only busy after gap: %b want 0", busy_o); end
   endtask

   task automatic test_data32();
      hdr[64*2 +: 64] = 64'h5B00_0000_0000_0002;
      data[64*2 +: 64] = 64'hDEAD_BEEF_1234_5678;
      dlen[2*2 +: 2] = 2'b01;
      req = 4'b0100;
      exp_q.push_back(mk(64'h5B00_0000_0000_0002, 4'b0100, 1'b0));
      exp_q.push_back(mk(64'h0000_0000_1234_5678, 4'b0100, 1'b1));
      step();
      n_vec++;
      if (grant_o !== 4'b0100) begin n_err++; $display("FAIL data32 grant: %b want 0100", grant_o); end
      hdr[64*2 +: 64] = '1;
      data[64*2 +: 64] = '0;
      dlen[2*2 +: 2] = 2'b00;
      drain(50);
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL data32 drain: %0d flits pending, want 0", exp_q.size()); end
      req = '0;
      exp_q.delete();
      wait_idle();
   endtask

   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         hdr[64*i +: 64] = 64'hC0DE_0000_0000_0000 + 64'(i);
         data[64*i +: 64] = 64'h1111_2222_3333_0000 + 64'(i * 16);
         dlen[2*i +: 2] = 2'b10;
      end
      for (int m = 0; m < 5; m++) begin
         exp_q.push_back(mk(64'hC0DE_0000_0000_0000 + 64'(order[m]), N'(1) << order[m], 1'b0));
         exp_q.push_back(mk(64'h1111_2222_3333_0000 + 64'(order[m] * 16), N'(1) << order[m], 1'b1));
      end
      gap_exact = 1;
      req = 4'b1111;
      drain(300);
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL rr drain: %0d flits pending, want 0", exp_q.size()); end
      req = '0;
      exp_q.delete();
      wait_idle();
      gap_exact = 0;
   endtask

   task automatic test_stall();
      logic [63:0] h;
      h = 64'h57A1_1000_0000_00AA;
      tx_ready = 1'b0;
      hdr[0 +: 64] = h;
      dlen[0 +: 2] = 2'b00;
      req = 4'b0001;
      exp_q.push_back(mk(h, 4'b0001, 1'b1));
      step();
      for (int k = 0; k < 10; k++) begin
         n_vec += 3;
         if (tx_valid_o !== 1'b1) begin n_err++; $display("FAIL stall %0d valid: %b want 1", k, tx_valid_o); end
         if (tx_data_o !== h) begin n_err++; $display("FAIL stall %0d data: %h want %h", k, tx_data_o, h); end
         if (ack_o !== '0) begin n_err++; $display("FAIL stall %0d ack: %b want 0", k, ack_o); end
         hdr[0 +: 64] = ~h;
         step();
      end
      tx_ready = 1'b1;
      drain(10);
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL stall drain: %0d flits pending, want 0", exp_q.size()); end
      req = '0;
      exp_q.delete();
      wait_idle();
   endtask

   task automatic test_enable();
      tx_ready = 1'b1;
      enable = 1'b1;
      hdr[64*3 +: 64] = 64'hE7AB_0000_0000_0003;
      data[64*3 +: 64] = 64'h0123_4567_89AB_CDEF;
      dlen[2*3 +: 2] = 2'b11;
      req = 4'b1000;
      exp_q.push_back(mk(64'hE7AB_0000_0000_0003, 4'b1000, 1'b0));
      exp_q.push_back(mk(64'h0123_4567_89AB_CDEF, 4'b1000, 1'b1));
      step();
      step();
      n_vec += 2;
      if (tx_valid_o !== 1'b1) begin n_err++; $display("FAIL enable data valid: %b want 1", tx_valid_o); end
      if (tx_data_o !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL enable data flit: %h want 0123456789abcdef", tx_data_o); end
      enable = 1'b0;
      tx_ready = 1'b0;
      req = 4'b1111;
      repeat (3) step();
      tx_ready = 1'b1;
      drain(10);
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL enable drain: %0d flits pending, want 0", exp_q.size()); end
      for (int k = 0; k < 15; k++) begin
         n_vec++;
         if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL enable off %0d valid: %b want 0", k, tx_valid_o); end
         step();
      end
      n_vec += 2;
      if (busy_o !== 1'b0) begin n_err++; $display("FAIL enable off busy: %b want 0", busy_o); end
      if (grant_o !== '0) begin n_err++; $display("FAIL enable off grant: %b want 0", grant_o); end
      req = '0;
      exp_q.delete();
      enable = 1'b1;
      step();
   endtask

   task automatic test_reset_abort();
      tx_ready = 1'b1;
      hdr[64*2 +: 64] = 64'hAB07_0000_0000_0002;
      data[64*2 +: 64] = 64'hFFFF_EEEE_CAFE_F00D;
      dlen[2*2 +: 2] = 2'b01;
      req = 4'b0100;
      exp_q.push_back(mk(64'hAB07_0000_0000_0002, 4'b0100, 1'b0));
      exp_q.push_back(mk(64'h0000_0000_CAFE_F00D, 4'b0100, 1'b1));
      step();
      step();
      tx_ready = 1'b0;
      n_vec++;
      if (tx_data_o !== 64'h0000_0000_CAFE_F00D) begin n_err++; $display("FAIL abort data flit: %h want 00000000cafef00d", tx_data_o); end
      step();
      reset_n = 1'b0;
      exp_q.delete();
      step();
      n_vec += 5;
      if (tx_data_o !== 64'd0) begin n_err++; $display("FAIL abort tx_data: %h want 0", tx_data_o); end
      if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL abort tx_valid: %b want 0", tx_valid_o); end
      if (grant_o !== '0) begin n_err++; $display("FAIL abort grant: %b want 0", grant_o); end
      if (ack_o !== '0) begin n_err++; $display("FAIL abort ack: %b want 0", ack_o); end
      if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort busy: %b want 0", busy_o); end
      req = '0;
      step();
      hdr[0 +: 64] = 64'h0000_0000_0000_AAA0;
      dlen[0 +: 2] = 2'b00;
      hdr[64*3 +: 64] = 64'h0000_0000_0000_AAA3;
      dlen[2*3 +: 2] = 2'b00;
      tx_ready = 1'b1;
      reset_n = 1'b1;
      req = 4'b1001;
      exp_q.push_back(mk(64'h0000_0000_0000_AAA0, 4'b0001, 1'b1));
      exp_q.push_back(mk(64'h0000_0000_0000_AAA3, 4'b1000, 1'b1));
      step();
      n_vec++;
      if (grant_o !== 4'b0001) begin n_err++; $display("FAIL abort first grant: %b want 0001", grant_o); end
      drain(60);
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL abort drain: %0d flits pending, want 0", exp_q.size()); end
      req = '0;
      exp_q.delete();
      wait_idle();
      step();
   endtask

   initial begin
      test_reset();
      test_hdr_only();
      test_data32();
      test_round_robin();
      test_stall();
      test_enable();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
      $fatal(1);
   end

endmodule
